// File: rtl/dpram_clr.sv
// dpram_clr: true dual-port synchronous RAM with registered reads on both
// ports and a built-in clear sequencer that fills the array with a pattern
// after reset or on request.
module dpram_clr #(
    parameter int unsigned   AW           = 16,
    parameter int unsigned   DW           = 8,
    parameter logic [DW-1:0] FILL         = '1,
    parameter bit            CLR_ON_RESET = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    input  logic          a_cs,
    input  logic          a_we,
    output logic [DW-1:0] a_q,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    input  logic          b_cs,
    input  logic          b_we,
    output logic [DW-1:0] b_q
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    localparam state_t        RST_STATE = CLR_ON_RESET ? S_FILL : S_IDLE;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_done_q, clr_done_d;
    logic          clr_busy_q;

    logic          fill_we;
    logic          a_wr;
    logic          b_wr;

    // Sequencer next-state: walk every address once, then report completion
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d   = S_FILL;
                    clr_cnt_d = '0;
                end
            end
            S_FILL: begin
                // counter naturally wraps to zero on the final write
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d    = S_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, counter, and registered busy/done flags
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= RST_STATE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            clr_busy_q <= CLR_ON_RESET;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            clr_busy_q <= (state_d == S_FILL);
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Write arbitration: sequencer owns the array in FILL; port A beats port B on the same address
    always_comb begin
        fill_we = (state_q == S_FILL) && !reset;
        a_wr    = (state_q == S_IDLE) && !reset && a_cs && a_we;
        b_wr    = (state_q == S_IDLE) && !reset && b_cs && b_we
                  && !(a_wr && (a_addr == b_addr));
    end

    // Array writes; contents are never reset
    always_ff @(posedge clk_sys) begin
        if (fill_we)
            mem[clr_cnt_q] <= FILL;
        if (a_wr)
            mem[a_addr] <= a_din;
        if (b_wr)
            mem[b_addr] <= b_din;
    end

    // Registered read ports returning pre-write (old) data
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_cs)
                a_q <= mem[a_addr];
            if (b_cs)
                b_q <= mem[b_addr];
        end
    end

endmodule

// File: tb/tb_dpram_clr.sv
// Scoreboard bench for dpram_clr: one instance clears on reset, the other
// comes out of reset idle. Read expectations are queued by the driver and
// checked by an independent monitor one cycle after the read is issued.
module tb_dpram_clr;

    logic       clk_sys;
    logic       rst     [2];
    logic       clr_req [2];
    logic       busy    [2];
    logic       done    [2];
    // port index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
    logic [3:0] addr [4];
    logic [7:0] din  [4];
    logic       cs   [4];
    logic       we   [4];
    logic [7:0] q    [4];
    logic       chkf [4];
    logic       pend [4];

    logic [7:0] sbq0[$];
    logic [7:0] sbq1[$];
    logic [7:0] sbq2[$];
    logic [7:0] sbq3[$];

    int total = 0;
    int bad   = 0;

    dpram_clr #(.AW(4), .DW(8), .FILL(8'hFF), .CLR_ON_RESET(1'b1)) u_dut0 (
        .clk_sys(clk_sys), .reset(rst[0]), .clr_req(clr_req[0]),
        .clr_busy(busy[0]), .clr_done(done[0]),
        .a_addr(addr[0]), .a_din(din[0]), .a_cs(cs[0]), .a_we(we[0]), .a_q(q[0]),
        .b_addr(addr[1]), .b_din(din[1]), .b_cs(cs[1]), .b_we(we[1]), .b_q(q[1])
    );

    dpram_clr #(.AW(4), .DW(8), .FILL(8'hFF), .CLR_ON_RESET(1'b0)) u_dut1 (
        .clk_sys(clk_sys), .reset(rst[1]), .clr_req(clr_req[1]),
        .clr_busy(busy[1]), .clr_done(done[1]),
        .a_addr(addr[2]), .a_din(din[2]), .a_cs(cs[2]), .a_we(we[2]), .a_q(q[2]),
        .b_addr(addr[3]), .b_din(din[3]), .b_cs(cs[3]), .b_we(we[3]), .b_q(q[3])
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void sb_push(input int p, input logic [7:0] e);
        case (p)
            0: sbq0.push_back(e);
            1: sbq1.push_back(e);
            2: sbq2.push_back(e);
            default: sbq3.push_back(e);
        endcase
    endfunction

    function automatic bit sb_pop(input int p, output logic [7:0] e);
        bit ok;
        ok = 1'b0;
        e  = '0;
        case (p)
            0: if (sbq0.size() > 0) begin e = sbq0.pop_front(); ok = 1'b1; end
            1: if (sbq1.size() > 0) begin e = sbq1.pop_front(); ok = 1'b1; end
            2: if (sbq2.size() > 0) begin e = sbq2.pop_front(); ok = 1'b1; end
            default: if (sbq3.size() > 0) begin e = sbq3.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    // Drive one port access for the coming edge; queue an expected read value if requested
    task automatic op(input int p, input bit w, input logic [3:0] ad, input logic [7:0] d,
                      input bit chk, input logic [7:0] e);
        cs[p]   = 1'b1;
        we[p]   = w;
        addr[p] = ad;
        din[p]  = d;
        if (chk) begin
            chkf[p] = 1'b1;
            sb_push(p, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        for (int p = 0; p < 4; p++) begin
            cs[p]   = 1'b0;
            we[p]   = 1'b0;
            chkf[p] = 1'b0;
        end
        clr_req[0] = 1'b0;
        clr_req[1] = 1'b0;
    endtask

    // Count busy cycles and done pulses of one instance, optionally injecting a
    // clr_req and a port-A write at given cycles of the measurement window
    task automatic measure(input int which, input int req_at, input int wr_at,
                           output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy[which]) bc++;
            if (done[which]) dc++;
            if (!busy[which] && bc > 0) break;
            if (i == req_at) clr_req[which] = 1'b1;
            if (i == wr_at) op(which * 2, 1'b1, 4'd2, 8'hAA, 1'b0, 8'h00);
            tick();
        end
        repeat (2) begin
            tick();
            if (done[which]) dc++;
        end
    endtask

    // Latch which ports expect a result from this edge
    always @(posedge clk_sys) begin
        for (int p = 0; p < 4; p++) pend[p] <= chkf[p];
    end

    // Monitor: compare registered read data against the scoreboard
    always @(negedge clk_sys) begin
        logic [7:0] e;
        for (int p = 0; p < 4; p++) begin
            if (pend[p]) begin
                if (sb_pop(p, e))
                    check($sformatf("rd_port%0d", p), int'(q[p]), int'(e));
                else
                    check($sformatf("sb_underflow_port%0d", p), 1, 0);
            end
        end
    end

    initial begin
        int bc, dc;
        rst[0] = 1'b1; rst[1] = 1'b1;
        clr_req[0] = 1'b0; clr_req[1] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            cs[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; din[p] = '0;
            chkf[p] = 1'b0; pend[p] = 1'b0;
        end
        #1;
        check("rst_a0_q", int'(q[0]), 0);
        check("rst_b0_q", int'(q[1]), 0);
        check("rst_a1_q", int'(q[2]), 0);
        check("rst_busy0", int'(busy[0]), 1);
        check("rst_busy1", int'(busy[1]), 0);
        check("rst_done0", int'(done[0]), 0);

        // 1: clear on reset release, then read every address
        repeat (3) tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        check("idle_busy1", int'(busy[1]), 0);
        measure(0, -1, -1, bc, dc);
        check("fill0_busy_cycles", bc, 16);
        check("fill0_done_pulses", dc, 1);
        for (int i = 0; i < 16; i++) begin
            op(0, 1'b0, 4'(i), 8'h00, 1'b1, 8'hFF);
            tick();
        end

        // 2: A write, B read one cycle later, B holds with cs low
        op(0, 1'b1, 4'd3, 8'h5A, 1'b0, 8'h00);
        tick();
        op(1, 1'b0, 4'd3, 8'h00, 1'b1, 8'h5A);
        tick();
        tick();
        tick();
        check("b_hold", int'(q[1]), 8'h5A);

        // 3: same-address collision, cross-port read-old, distinct-address double write
        op(0, 1'b1, 4'd7, 8'h11, 1'b0, 8'h00);
        op(1, 1'b1, 4'd7, 8'h22, 1'b0, 8'h00);
        tick();
        op(0, 1'b0, 4'd7, 8'h00, 1'b1, 8'h11);
        op(1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h11);
        tick();
        op(0, 1'b1, 4'd1, 8'h33, 1'b0, 8'h00);
        op(1, 1'b0, 4'd1, 8'h00, 1'b1, 8'hFF);
        tick();
        op(1, 1'b0, 4'd1, 8'h00, 1'b1, 8'h33);
        tick();
        op(0, 1'b1, 4'd4, 8'h44, 1'b0, 8'h00);
        op(1, 1'b1, 4'd5, 8'h55, 1'b0, 8'h00);
        tick();
        op(0, 1'b0, 4'd5, 8'h00, 1'b1, 8'h55);
        op(1, 1'b0, 4'd4, 8'h00, 1'b1, 8'h44);
        tick();

        // 5: abort a requested clear at clr_cnt=8 with reset, then a full restart
        op(0, 1'b1, 4'd0,  8'h00, 1'b0, 8'h00);
        op(1, 1'b1, 4'd15, 8'h00, 1'b0, 8'h00);
        tick();
        op(0, 1'b0, 4'd3, 8'h00, 1'b1, 8'h5A);
        op(1, 1'b0, 4'd4, 8'h00, 1'b1, 8'h44);
        tick();
        tick();
        check("pre_abort_a0_q", int'(q[0]), 8'h5A);
        clr_req[0] = 1'b1;
        tick();
        check("req_busy0", int'(busy[0]), 1);
        dc = 0;
        repeat (8) begin
            tick();
            if (done[0]) dc++;
        end
        #2;
        rst[0] = 1'b1;
        #1;
        check("abort_a0_q", int'(q[0]), 0);
        check("abort_b0_q", int'(q[1]), 0);
        check("abort_busy0", int'(busy[0]), 1);
        repeat (2) begin
            tick();
            if (done[0]) dc++;
        end
        check("abort_no_done", dc, 0);
        rst[0] = 1'b0;
        measure(0, -1, -1, bc, dc);
        check("refill0_busy_cycles", bc, 16);
        check("refill0_done_pulses", dc, 1);
        op(0, 1'b0, 4'd0,  8'h00, 1'b1, 8'hFF);
        op(1, 1'b0, 4'd15, 8'h00, 1'b1, 8'hFF);
        tick();
        op(0, 1'b0, 4'd3, 8'h00, 1'b1, 8'hFF);
        tick();

        // 4 + 6: idle instance, requested clear drops a write and ignores a repeat request
        op(2, 1'b1, 4'd9, 8'h00, 1'b0, 8'h00);
        tick();
        op(2, 1'b0, 4'd9, 8'h00, 1'b1, 8'h00);
        tick();
        clr_req[1] = 1'b1;
        tick();
        measure(1, 9, 6, bc, dc);
        check("fill1_busy_cycles", bc, 16);
        check("fill1_done_pulses", dc, 1);
        op(2, 1'b0, 4'd9, 8'h00, 1'b1, 8'hFF);
        op(3, 1'b0, 4'd2, 8'h00, 1'b1, 8'hFF);
        tick();
        op(2, 1'b0, 4'd2, 8'h00, 1'b1, 8'hFF);
        tick();
        tick();
        tick();

        check("sb_drain", sbq0.size() + sbq1.size() + sbq2.size() + sbq3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_clr.md
Name: dpram_clr

Overview:
Parametrised true dual-port synchronous RAM for system memory, e.g. the Oric main RAM shared by CPU and video/loader ports.
Each port has its own registered read.
A built-in clear sequencer fills the whole array with a programmable pattern after reset or on request, so the top level needs no external clear-address counter.
Write collisions between the two ports and the clear sequencer resolve deterministically.

Parameters:
AW, 16, address width; depth = 2**AW words
DW, 8, data width
FILL, all ones (DW bits), pattern written by the clear sequencer
CLR_ON_RESET, 1, 1 = start a clear automatically when reset deasserts; 0 = come out of reset idle

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
clr_req  in  1  start-clear request, sampled in IDLE only
clr_busy  out  1  high while the sequencer owns the array
clr_done  out  1  one-cycle pulse on the cycle after the last fill write
a_addr  in  AW  port A address
a_din  in  DW  port A write data
a_cs  in  1  port A select
a_we  in  1  port A write enable (effective only with a_cs)
a_q  out  DW  port A registered read data
b_addr  in  AW  port B address
b_din  in  DW  port B write data
b_cs  in  1  port B select
b_we  in  1  port B write enable (effective only with b_cs)
b_q  out  DW  port B registered read data

Behaviour:
- Reset is asynchronous and active-high. While reset=1:
  - a_q=0, b_q=0, clr_done=0, clr_cnt=0.
  - state=FILL and clr_busy=1 if CLR_ON_RESET=1; otherwise state=IDLE and clr_busy=0.
  - No array writes occur during reset. Array contents are not reset.
- FSM states: IDLE, FILL.
  - IDLE -> FILL when clr_req=1; clr_cnt loads 0. The first fill write happens on the cycle after entry.
  - FILL: every cycle write FILL to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt == 2**AW-1, that write is the last one: go to IDLE and pulse clr_done=1 for exactly one cycle, coincident with the first IDLE cycle.
  - A full clear takes exactly 2**AW cycles.
  - clr_req while in FILL is ignored; the clear does not restart.
- clr_busy = (state==FILL), registered.
- Reset asserted mid-FILL aborts the clear. clr_done does not pulse. After deassertion, behaviour follows CLR_ON_RESET, restarting from address 0.
- Read path, per port independently:
  - If x_cs=1 at an edge, x_q <= mem[x_addr] as it was before that edge's writes (read-old-data).
  - If x_cs=0, x_q holds its value.
  - Read latency is 1 cycle.
  - Reads are permitted during FILL and return whatever the array currently holds.
- Write path:
  - In IDLE, port A writes when a_cs&a_we; port B writes when b_cs&b_we.
  - In FILL, all port writes are suppressed and dropped, not queued.
  - Same-address double write in one cycle: port A wins; port B's data is discarded.
  - Different addresses: both writes commit.
- Cross-port read of an address the other port writes in the same cycle returns the old data; the new data is visible on the next access.
- No address wrap: the address ranges over exactly 2**AW words. clr_cnt wraps to 0 only implicitly, as the FSM leaves FILL.

Test Plan:
1. AW=4, DW=8, CLR_ON_RESET=1; hold reset 3 cycles, release -> clr_busy=1 for exactly 16 cycles, clr_done pulses once; a later A read of every address returns 8'hFF with 1-cycle latency.
2. After clear, A writes 8'h5A@3; next cycle B reads @3 -> b_q=8'h5A one cycle later; with b_cs=0 afterwards, b_q holds 8'h5A.
3. Same cycle A writes 8'h11@7 and B writes 8'h22@7 -> later read @7 gives 8'h11. In another cycle, A writes 8'h33@1 while B reads @1 -> b_q=old value 8'hFF.
4. CLR_ON_RESET=0: release reset -> clr_busy=0. Write 8'h00@9, assert clr_req one cycle -> busy for 16 cycles. A write 8'hAA@2 issued during FILL is dropped; @9 and @2 both read 8'hFF.
5. Assert reset at clr_cnt=8 mid-FILL -> a_q=b_q=0 immediately (asynchronous), no clr_done. After release, the FILL restarts at 0 and lasts the full 16 cycles.
6. clr_req pulsed again during FILL -> ignored; total busy remains 16 cycles and clr_done pulses once.
